// File: rtl/noc_pkg.sv
// Shared width and bus-slicing helpers for the NoC distribution blocks.
package noc_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/distribute_fifo_seq.sv
// Single-clock branch FIFO with registered head word, valid flag and occupancy.
// The head register reads zero whenever the FIFO is empty.
module distribute_fifo_seq
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [DATA_WIDTH-1:0]              din,
  output logic [DATA_WIDTH-1:0]              dout,
  output logic                               full,
  output logic                               empty,
  output logic [cnt_width(FIFO_DEPTH)-1:0]   count
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(32'd1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(32'd1);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r, rd_next_s, wr_next_s;
  logic [CNT_W-1:0]      count_r, count_next_s;
  logic [DATA_WIDTH-1:0] head_r, head_next_s;
  logic                  valid_r, push_s, pop_s;

  // Next pointers, occupancy and head word; a push into a slot that becomes the head bypasses memory.
  always_comb begin
    push_s = push & (count_r != FULL_CNT);
    pop_s  = pop & valid_r;
    if (pop_s) begin
      rd_next_s = rd_ptr_r + ONE_PTR;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_next_s = wr_ptr_r + ONE_PTR;
    end else begin
      wr_next_s = wr_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_CNT;
      2'b01:   count_next_s = count_r - ONE_CNT;
      default: count_next_s = count_r;
    endcase
    if (count_next_s == {CNT_W{1'b0}}) begin
      head_next_s = {DATA_WIDTH{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = din;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 32'sd0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {DATA_WIDTH{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
      end
      rd_ptr_r <= rd_next_s;
      wr_ptr_r <= wr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      valid_r  <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  assign dout  = head_r;
  assign empty = ~valid_r;
  assign full  = (count_r == FULL_CNT);
  assign count = count_r;

endmodule

// File: rtl/distribute_1xn_buffered_seq.sv
// 1-to-N distribute switch: a word is pushed atomically into every branch FIFO named
// by the destination mask; each branch drains independently through valid/ready.
module distribute_1xn_buffered_seq
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUTPUT = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_valid,
  output logic                                           i_ready,
  input  logic [DATA_WIDTH-1:0]                          i_data_bus,
  input  logic [NUM_OUTPUT-1:0]                          i_cmd,
  input  logic                                           i_en,
  output logic [NUM_OUTPUT-1:0]                          o_valid,
  input  logic [NUM_OUTPUT-1:0]                          o_ready,
  output logic [NUM_OUTPUT*DATA_WIDTH-1:0]               o_data_bus,
  output logic [NUM_OUTPUT*cnt_width(FIFO_DEPTH)-1:0]    o_count
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic [NUM_OUTPUT-1:0] full_s;
  logic [NUM_OUTPUT-1:0] empty_s;
  logic [NUM_OUTPUT-1:0] push_s;
  logic                  accept_s;

  // Acceptance uses only registered fullness, so no ready path runs through o_ready.
  always_comb begin
    i_ready  = rst & i_en & ~(|(i_cmd & full_s));
    accept_s = i_valid & i_ready;
    push_s   = i_cmd & {NUM_OUTPUT{accept_s}};
  end

  for (genvar k = 0; k < NUM_OUTPUT; k++) begin : g_branch
    localparam int D_LO = slice_lo(k, DATA_WIDTH);
    localparam int C_LO = slice_lo(k, CNT_W);

    distribute_fifo_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[k]),
      .pop   (o_ready[k]),
      .din   (i_data_bus),
      .dout  (o_data_bus[D_LO +: DATA_WIDTH]),
      .full  (full_s[k]),
      .empty (empty_s[k]),
      .count (o_count[C_LO +: CNT_W])
    );

    assign o_valid[k] = ~empty_s[k];
  end

endmodule

// File: tb/tb_distribute_1xn_buffered_seq.sv
// Bench for distribute_1xn_buffered_seq: directed table, corner sequences and
// random traffic checked against a queue-per-branch reference model.
module tb_distribute_1xn_buffered_seq;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid, i_ready, i_en;
  logic [DW-1:0] i_data_bus;
  logic [N-1:0]  i_cmd, o_valid, o_ready;
  logic [N*DW-1:0] o_data_bus;
  logic [N*CW-1:0] o_count;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq  [N][$];
  logic [DW-1:0] got [N][$];

  typedef struct {
    logic          v;
    logic [3:0]    cmd;
    logic [31:0]   d;
    logic          en;
    logic [3:0]    ordy;
    logic          e_ready;
    logic [3:0]    e_valid;
    logic [7:0]    e_count;
    logic [31:0]   e_d0;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  distribute_1xn_buffered_seq #(.DATA_WIDTH(DW), .NUM_OUTPUT(N), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .i_en       (i_en),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data_bus (o_data_bus),
    .o_count    (o_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference acceptance rule: enabled and every selected branch below capacity.
  function automatic logic mdl_ready(input logic [3:0] cmd, input logic en);
    logic r;
    r = en;
    for (int k = 0; k < N; k++) begin
      if (cmd[k] && mq[k].size() >= D) r = 1'b0;
    end
    return r;
  endfunction

  task automatic check_all(input logic [3:0] cmd, input logic en, input string tag);
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    logic [N*CW-1:0] ec;
    for (int k = 0; k < N; k++) begin
      ev[k] = (mq[k].size() > 0);
      ed[k*DW +: DW] = (mq[k].size() > 0) ? mq[k][0] : 32'h0;
      ec[k*CW +: CW] = CW'(mq[k].size());
    end
    chk({tag, "/i_ready"}, 128'(i_ready), 128'(mdl_ready(cmd, en)));
    chk({tag, "/o_valid"}, 128'(o_valid), 128'(ev));
    chk({tag, "/o_data"},  128'(o_data_bus), 128'(ed));
    chk({tag, "/o_count"}, 128'(o_count), 128'(ec));
  endtask

  task automatic mdl_step(input logic v, input logic [3:0] cmd, input logic [31:0] d,
                          input logic en, input logic [3:0] ordy);
    logic acc;
    acc = v & mdl_ready(cmd, en);
    for (int k = 0; k < N; k++) begin
      if (mq[k].size() > 0 && ordy[k]) void'(mq[k].pop_front());
    end
    for (int k = 0; k < N; k++) begin
      if (acc && cmd[k]) mq[k].push_back(d);
    end
  endtask

  // One clock: drive at edge+1, check at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic v, input logic [3:0] cmd, input logic [31:0] d,
                     input logic en, input logic [3:0] ordy, input string tag, output logic acc);
    i_valid = v; i_cmd = cmd; i_data_bus = d; i_en = en; o_ready = ordy;
    @(negedge clk);
    check_all(cmd, en, tag);
    for (int k = 0; k < N; k++) begin
      if (o_valid[k] && ordy[k]) got[k].push_back(o_data_bus[k*DW +: DW]);
    end
    acc = v & mdl_ready(cmd, en);
    @(posedge clk);
    mdl_step(v, cmd, d, en, ordy);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int word, first_ref, stall, bad;

    tbl[0] = '{1'b1, 4'b0001, 32'hA5A5A5A5, 1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00, 32'h00000000};
    tbl[1] = '{1'b1, 4'b0000, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'h01, 32'hA5A5A5A5};
    tbl[2] = '{1'b1, 4'b0011, 32'h11111111, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'h01, 32'hA5A5A5A5};
    tbl[3] = '{1'b1, 4'b0001, 32'h22222222, 1'b1, 4'b0000, 1'b0, 4'b0011, 8'h06, 32'hA5A5A5A5};
    tbl[4] = '{1'b1, 4'b0001, 32'h22222222, 1'b1, 4'b0001, 1'b0, 4'b0011, 8'h06, 32'hA5A5A5A5};
    tbl[5] = '{1'b1, 4'b0001, 32'h22222222, 1'b1, 4'b0001, 1'b1, 4'b0011, 8'h05, 32'h11111111};
    tbl[6] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b1111, 1'b1, 4'b0011, 8'h05, 32'h22222222};
    tbl[7] = '{1'b1, 4'b1111, 32'h33333333, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 32'h00000000};

    // Reset held with random traffic
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_en = 1'b1; i_cmd = 4'($urandom); i_data_bus = $urandom; o_ready = 4'($urandom);
      @(negedge clk);
      chk("rst/o_valid", 128'(o_valid), 128'(0));
      chk("rst/o_data",  128'(o_data_bus), 128'(0));
      chk("rst/o_count", 128'(o_count), 128'(0));
      chk("rst/i_ready", 128'(i_ready), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed table
    for (int r = 0; r < 8; r++) begin
      i_valid = tbl[r].v; i_cmd = tbl[r].cmd; i_data_bus = tbl[r].d; i_en = tbl[r].en; o_ready = tbl[r].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d/i_ready", r), 128'(i_ready), 128'(tbl[r].e_ready));
      chk($sformatf("tbl%0d/o_valid", r), 128'(o_valid), 128'(tbl[r].e_valid));
      chk($sformatf("tbl%0d/o_count", r), 128'(o_count), 128'(tbl[r].e_count));
      chk($sformatf("tbl%0d/data0", r), 128'(o_data_bus[DW-1:0]), 128'(tbl[r].e_d0));
      @(posedge clk);
      mdl_step(tbl[r].v, tbl[r].cmd, tbl[r].d, tbl[r].en, tbl[r].ordy);
      #1;
    end

    // Broadcast with branch 3 stalled
    for (int k = 0; k < N; k++) got[k].delete();
    word = 1; first_ref = 0; stall = 0;
    for (int c = 0; c < 40 && word <= 4; c++) begin
      cyc(1'b1, 4'b1111, 32'(word), 1'b1, (stall >= 3) ? 4'b1111 : 4'b0111, "bcast", acc);
      if (acc) begin
        word++;
      end else begin
        if (first_ref == 0) begin
          first_ref = word;
          chk("bcast/count3_stalled", 128'(o_count[3*CW +: CW]), 128'(2));
        end
        stall++;
      end
    end
    chk("bcast/all_accepted", 128'(word), 128'(5));
    chk("bcast/first_refused", 128'(first_ref), 128'(3));
    repeat (4) cyc(1'b0, 4'b0000, 32'h0, 1'b1, 4'b1111, "bcast_drain", acc);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("bcast/got%0d_len", k), 128'(got[k].size()), 128'(4));
      for (int i = 0; i < got[k].size() && i < 4; i++)
        chk($sformatf("bcast/got%0d_%0d", k, i), 128'(got[k][i]), 128'(i + 1));
    end

    // Atomic multicast against a full branch 2
    cyc(1'b1, 4'b0100, 32'hC0, 1'b1, 4'b0000, "atom_fill", acc);
    cyc(1'b1, 4'b0100, 32'hC1, 1'b1, 4'b0000, "atom_fill", acc);
    cyc(1'b1, 4'b0110, 32'hBAD, 1'b1, 4'b0000, "atom_refuse", acc);
    chk("atom/count1_untouched", 128'(o_count[1*CW +: CW]), 128'(0));
    cyc(1'b1, 4'b0011, 32'h0D, 1'b1, 4'b0000, "atom_other", acc);
    chk("atom/count0_after", 128'(o_count[0 +: CW]), 128'(1));
    chk("atom/count1_after", 128'(o_count[1*CW +: CW]), 128'(1));
    repeat (3) cyc(1'b0, 4'b0000, 32'h0, 1'b1, 4'b1111, "atom_drain", acc);

    // Streaming push+pop through a one-entry branch 0
    for (int k = 0; k < N; k++) got[k].delete();
    cyc(1'b1, 4'b0001, 32'd0, 1'b1, 4'b0000, "stream", acc);
    for (int i = 1; i < 100; i++) cyc(1'b1, 4'b0001, 32'(i), 1'b1, 4'b0001, "stream", acc);
    repeat (2) cyc(1'b0, 4'b0000, 32'h0, 1'b1, 4'b0001, "stream_drain", acc);
    chk("stream/len", 128'(got[0].size()), 128'(100));
    bad = 0;
    for (int i = 0; i < got[0].size(); i++) if (got[0][i] !== 32'(i)) bad++;
    chk("stream/order_errors", 128'(bad), 128'(0));

    // Enable low with pending data
    repeat (2) cyc(1'b1, 4'b1111, 32'hAA, 1'b1, 4'b0000, "en_fill", acc);
    repeat (3) cyc(1'b1, 4'b1111, 32'hBB, 1'b0, 4'b1111, "en_low", acc);
    chk("en/drained", 128'(o_valid), 128'(0));

    // Asynchronous reset with two entries buffered
    cyc(1'b1, 4'b0001, 32'hE1, 1'b1, 4'b0000, "arst_fill", acc);
    cyc(1'b1, 4'b0001, 32'hE2, 1'b1, 4'b0000, "arst_fill", acc);
    i_valid = 1'b0; i_cmd = 4'b0000; i_en = 1'b1; o_ready = 4'b0000;
    #2 rst = 1'b0;
    #1;
    chk("arst/o_valid", 128'(o_valid), 128'(0));
    chk("arst/o_count", 128'(o_count), 128'(0));
    chk("arst/o_data",  128'(o_data_bus), 128'(0));
    chk("arst/i_ready", 128'(i_ready), 128'(0));
    for (int k = 0; k < N; k++) mq[k].delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 7) != 0),
          4'($urandom), "rand", acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
